serial_sub_nb: RTL



---
 rtl/serial_sub_nb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_sub_nb.sv
// -----------------------------------------------------------------------------
// serial_sub_nb
//   Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock,
//   behind a start/ready/busy/done handshake. Results are registered and held
//   until the completing edge of the next accepted operation.
//
// Optional build macro:
//   SERIAL_SUB_OVF_EN - adds the ovf output. It carries the two's-complement
//                       signed overflow, taken as the borrow into the MSB
//                       XOR the borrow out of the MSB.
//
// Parameters:
//   WIDTH - operand/result width (2..32)
//   CNT_W - bit-counter width, derived from WIDTH; leave at its default
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - request a new operation; sampled only while ready=1
//   a, b   - minuend / subtrahend, latched on an accepted start
//   b_in   - borrow-in, latched on an accepted start
//   ready  - block can accept start (IDLE or DONE)
//   busy   - operation in progress (SHIFT)
//   done   - one-cycle completion pulse
//   diff   - registered difference
//   b_out  - registered borrow-out (1 when a < b + b_in, unsigned)
//   ovf    - registered signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_sub_nb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // One full-subtractor cell applied to the current LSBs.
    always_comb begin
        d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
        br_next  = (~a_sh_reg[0] & b_sh_reg[0]) |
                   (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
        res_next = {d_bit, res_sh_reg[WIDTH-1:1]};
        last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    // Handshake outputs depend on registered state only; start affects
    // nothing combinationally except the next-state decision.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff       <= '0;
            b_out      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_sh_reg   <= a;
                b_sh_reg   <= b;
                br_reg     <= b_in;
                res_sh_reg <= '0;
                cnt_reg    <= '0;
            end else if (state_reg == SHIFT) begin
                a_sh_reg   <= a_sh_reg >> 1;
                b_sh_reg   <= b_sh_reg >> 1;
                br_reg     <= br_next;
                res_sh_reg <= res_next;
                cnt_reg    <= cnt_reg + CNT_W'(1);
                // The final bit goes straight into the held outputs so the
                // result is visible in the DONE cycle.
                if (last_bit) begin
                    diff  <= res_next;
                    b_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // br_reg is the borrow into the MSB on this last step.
                    ovf   <= br_reg ^ br_next;
`endif
                end
            end
        end
    end

endmodule
